mac_result_accumulator: RTL

- Downstream consumer of the sequential Booth multiplier.
- Collects a run of signed products through the multiplier's done/recieved handshake and sums them into a wide signed accumulator. Used for dot-product and MAC workloads.
- Presents the final sum on a valid/ready output port.
- Sits between the multiplier's C/done outputs and the result sink.

---
 rtl/mac_result_accumulator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mac_result_accumulator.sv
`default_nettype none
//==============================================================================
// Module      : mac_result_accumulator
// Description : Sums a run of signed products from the sequential Booth
//               multiplier. Products arrive through the multiplier's
//               done/recieved handshake. The final sum is offered on a
//               valid/ready output port.
// Options     : MAC_ACC_SATURATE_EN - when defined, a signed overflow clamps
//               the accumulator to the most positive or most negative value.
//               When undefined, the accumulator wraps modulo 2^ACC_W. The
//               sticky overflow flag is raised in both builds.
// Revision    : 1.0 - initial release
//==============================================================================
module mac_result_accumulator #(
    parameter int N     = 32,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               mul_done,
    input  logic [2*N-1:0]     mul_prod,
    output logic               mul_recieved,
    output logic [ACC_W-1:0]   acc_out,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic               busy,
    output logic               overflow
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_ST_DROP      = 2'd2;
    localparam logic [1:0] c_ST_OUT       = 2'd3;

    localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_remaining;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_recieved;
    logic             r_valid;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic             w_recieved_nxt;
    logic             w_valid_nxt;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic [ACC_W-1:0] w_add_res;

    // Sign-extend the 2N-bit product to the accumulator width.
    assign w_prod_ext = ACC_W'($signed(mul_prod));
    assign w_sum      = r_acc + w_prod_ext;

    // Overflow only when both operands share a sign the result does not keep.
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef MAC_ACC_SATURATE_EN
    // Clamp toward the sign of the operands when the add overflows.
    assign w_add_res  = w_add_ovf ? (r_acc[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX)
                                  : w_sum;
`else
    // Plain modulo-2^ACC_W wraparound.
    assign w_add_res  = w_sum;
`endif

    // Registered state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_recieved  <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_recieved  <= w_recieved_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
        end
    end

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_acc_nxt       = r_acc;
        w_ovf_nxt       = r_ovf;
        w_recieved_nxt  = r_recieved;
        w_valid_nxt     = r_valid;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_acc_nxt       = '0;
                    w_ovf_nxt       = 1'b0;
                    w_remaining_nxt = len;
                    if (len == '0) begin
                        // Empty run reports a zero sum straight away.
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else begin
                        w_state_nxt = c_ST_WAIT_DONE;
                    end
                end
            end

            c_ST_WAIT_DONE: begin
                if (mul_done) begin
                    w_acc_nxt      = w_add_res;
                    w_ovf_nxt      = r_ovf | w_add_ovf;
                    if (r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - 1'b1;
                    end
                    w_recieved_nxt = 1'b1;
                    w_state_nxt    = c_ST_DROP;
                end
            end

            c_ST_DROP: begin
                // The multiplier keeps done high one extra cycle after the
                // acknowledge; wait it out so the product is taken only once.
                if (!mul_done) begin
                    w_recieved_nxt = 1'b0;
                    if (r_remaining == '0) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else begin
                        w_state_nxt = c_ST_WAIT_DONE;
                    end
                end
            end

            c_ST_OUT: begin
                if (acc_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_recieved_nxt = 1'b0;
                w_valid_nxt    = 1'b0;
            end
        endcase
    end

    assign mul_recieved = r_recieved;
    assign acc_out      = r_acc;
    assign acc_valid    = r_valid;
    assign busy         = r_busy;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire
